// File: rtl/design1_wrapper.sv
// AXI4-Lite hosted BRAM with a word-granular MM2S->S2MM copy engine.
// Define DMA_BYTECOUNT_EN to add the XFER byte counter at register 0x1C.
module design1_wrapper #(
  parameter int MEM_BYTES  = 8192,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axil_awaddr,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0]  s_axil_wstrb,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  output logic [1:0]  s_axil_bresp,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  input  logic [31:0] s_axil_araddr,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready
);

  localparam int AW = $clog2(MEM_BYTES / 4);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] F_FULL = (FW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic          live;
  logic          aw_got, w_got;
  logic [3:0]    aw_win, ar_win;
  logic [AW+1:0] aw_off, ar_off;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          ph1, ph2;
  logic [31:0]   reg_q, mem_q, reg_rd;
  logic [31:0]   src_r, dst_r;
  logic [29:0]   len_w;
  state_t        state;
  logic          done;
  logic [AW-1:0] src_p, dst_p;
  logic [29:0]   rd_left;
  logic [FW-1:0] wp, rp;
  logic [FW:0]   cnt;
  logic [31:0]   fifo [FIFO_DEPTH];
  logic [31:0]   mem  [MEM_BYTES/4];
`ifdef DMA_BYTECOUNT_EN
  logic [31:0]   xfer;
`endif

  logic aw_mem, aw_reg, ar_mem, ar_reg;
  logic host_wr, rd_ok, eng_slot, eng_wr, eng_rd, start;
  logic unused_ok;

  assign unused_ok = &{1'b0, s_axil_awaddr[27:AW+2],
                       s_axil_araddr[27:AW+2]};

  assign aw_mem = aw_win == 4'hD;
  assign aw_reg = aw_win == 4'h4;
  assign ar_mem = ar_win == 4'hD;
  assign ar_reg = ar_win == 4'h4;

  assign host_wr = aw_got & w_got & ~s_axil_bvalid;
  assign rd_ok   = ph1 & ~host_wr;
  // Host owns the single memory port whenever it needs it
  assign eng_slot = ~(host_wr & aw_mem) & ~(rd_ok & ar_mem);
  assign eng_wr = eng_slot && state == S_RUN && cnt != '0;
  assign eng_rd = eng_slot && state == S_RUN && !eng_wr
               && rd_left != '0 && cnt != F_FULL;
  assign start = host_wr && aw_reg && aw_off[7:0] == 8'h00
              && w_data[0];

  assign s_axil_awready = live & ~aw_got & ~s_axil_bvalid;
  assign s_axil_wready  = live & ~w_got & ~s_axil_bvalid;
  assign s_axil_arready = live & ~ph1 & ~ph2 & ~s_axil_rvalid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live <= 1'b0;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      aw_win <= '0;
      aw_off <= '0;
      w_data <= '0;
      w_strb <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp <= 2'b00;
    end else begin
      live <= 1'b1;
      if (s_axil_awvalid && s_axil_awready) begin
        aw_got <= 1'b1;
        aw_win <= s_axil_awaddr[31:28];
        aw_off <= s_axil_awaddr[AW+1:0];
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_got <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
      if (host_wr) begin
        aw_got <= 1'b0;
        w_got <= 1'b0;
        s_axil_bvalid <= 1'b1;
        s_axil_bresp <= (aw_mem || aw_reg) ? 2'b00 : 2'b11;
      end else if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    reg_rd = '0;
    unique case (ar_off[7:0])
      8'h04: reg_rd = {30'd0, state != S_RUN, done};
      8'h10: reg_rd = src_r;
      8'h14: reg_rd = dst_r;
      8'h18: reg_rd = {len_w, 2'b00};
`ifdef DMA_BYTECOUNT_EN
      8'h1C: reg_rd = xfer;
`endif
      default: reg_rd = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ph1 <= 1'b0;
      ph2 <= 1'b0;
      ar_win <= '0;
      ar_off <= '0;
      reg_q <= '0;
      s_axil_rvalid <= 1'b0;
      s_axil_rdata <= '0;
      s_axil_rresp <= 2'b00;
    end else begin
      if (s_axil_arvalid && s_axil_arready) begin
        ar_win <= s_axil_araddr[31:28];
        ar_off <= s_axil_araddr[AW+1:0];
        ph1 <= 1'b1;
      end
      if (rd_ok) begin
        ph1 <= 1'b0;
        ph2 <= 1'b1;
        reg_q <= reg_rd;
      end
      if (ph2) begin
        ph2 <= 1'b0;
        s_axil_rvalid <= 1'b1;
        s_axil_rdata <= ar_mem ? mem_q : ar_reg ? reg_q : '0;
        s_axil_rresp <= (ar_mem || ar_reg) ? 2'b00 : 2'b11;
      end else if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      src_r <= '0;
      dst_r <= '0;
      len_w <= '0;
    end else if (host_wr && aw_reg) begin
      unique case (aw_off[7:0])
        8'h10: src_r <= w_data;
        8'h14: dst_r <= w_data;
        8'h18: len_w <= w_data[31:2];
        default: ;
      endcase
    end
  end

  // Engine reads land straight in the FIFO slot (one-cycle BRAM read)
  always_ff @(posedge aclk) begin
    if (host_wr && aw_mem) begin
      for (int b = 0; b < 4; b++)
        if (w_strb[b])
          mem[aw_off[AW+1:2]][8*b +: 8] <= w_data[8*b +: 8];
    end else if (rd_ok && ar_mem) begin
      mem_q <= mem[ar_off[AW+1:2]];
    end else if (eng_wr) begin
      mem[dst_p] <= fifo[rp];
    end else if (eng_rd) begin
      fifo[wp] <= mem[src_p];
    end
  end

  logic [29:0] wr_left;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
      done <= 1'b0;
      src_p <= '0;
      dst_p <= '0;
      rd_left <= '0;
      wr_left <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
`ifdef DMA_BYTECOUNT_EN
      xfer <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          src_p <= src_r[AW+1:2];
          dst_p <= dst_r[AW+1:2];
          rd_left <= len_w;
          wr_left <= len_w;
          done <= 1'b0;
          wp <= '0;
          rp <= '0;
          cnt <= '0;
`ifdef DMA_BYTECOUNT_EN
          xfer <= '0;
`endif
          state <= (len_w == '0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (eng_rd) begin
            src_p <= src_p + 1'b1;
            rd_left <= rd_left - 1'b1;
            wp <= wp + 1'b1;
            cnt <= cnt + 1'b1;
          end
          if (eng_wr) begin
            dst_p <= dst_p + 1'b1;
            wr_left <= wr_left - 1'b1;
            rp <= rp + 1'b1;
            cnt <= cnt - 1'b1;
`ifdef DMA_BYTECOUNT_EN
            xfer <= xfer + 32'd4;
`endif
            if (wr_left == 30'd1) state <= S_DONE;
          end
        end
        S_DONE: begin
          done <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_design1_wrapper.sv
// Scoreboard bench for design1_wrapper: AXI-Lite driver plus
// a decoupled monitor popping expected B/R responses.
module tb_design1_wrapper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;
  logic [1:0]  bresp, rresp;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        chk;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  resp;
  } wexp_t;

  rexp_t rq[$];
  wexp_t wq[$];
  rexp_t re;
  wexp_t we;

`ifdef DMA_BYTECOUNT_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  always #5 clk = ~clk;

  design1_wrapper dut (
    .aclk(clk),
    .aresetn(rst_n),
    .s_axil_awaddr(awaddr),
    .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata),
    .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid),
    .s_axil_wready(wready),
    .s_axil_bresp(bresp),
    .s_axil_bvalid(bvalid),
    .s_axil_bready(bready),
    .s_axil_araddr(araddr),
    .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata(rdata),
    .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid),
    .s_axil_rready(rready)
  );

  function automatic logic [31:0] pat(input int i);
    int b;
    b = 4 * i;
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return (a[31:28] == 4'h4 || a[31:28] == 4'hD) ? 2'b00 : 2'b11;
  endfunction

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic abort(input string what);
    errors++;
    checks++;
    $display("FAIL timeout_%s: got no response, required one within budget",
             what);
    finish_run();
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    logic ah, wh;
    we.addr = a;
    we.resp = exp_resp(a);
    wq.push_back(we);
    awaddr = a;
    wdata = d;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 200) begin
      @(negedge clk);
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(posedge clk); #1;
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
      n++;
    end
    if (awvalid || wvalid) abort("aw_w");
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (bvalid) break;
      n++;
    end
    if (!bvalid) abort("b");
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    logic ah;
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 200) begin
      @(negedge clk);
      ah = arready;
      @(posedge clk); #1;
      if (ah) arvalid = 1'b0;
      n++;
    end
    if (arvalid) abort("ar");
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (rvalid) break;
      n++;
    end
    if (!rvalid) abort("r");
    d = rdata;
    @(posedge clk); #1;
  endtask

  task automatic chk_read(input logic [31:0] a, input logic [31:0] e);
    logic [31:0] d;
    rexp_t x;
    x.chk = 1'b1;
    x.addr = a;
    x.data = e;
    x.resp = exp_resp(a);
    rq.push_back(x);
    axi_read(a, d);
  endtask

  task automatic poll_read(input logic [31:0] a, output logic [31:0] d);
    rexp_t x;
    x.chk = 1'b0;
    x.addr = a;
    x.data = '0;
    x.resp = 2'b00;
    rq.push_back(x);
    axi_read(a, d);
  endtask

  task automatic wait_done();
    int n;
    logic [31:0] d;
    n = 0;
    do begin
      poll_read(32'h4000_0004, d);
      n++;
    end while (d != 32'd3 && n < 3000);
    if (d != 32'd3) abort("done_poll");
    chk_read(32'h4000_0004, 32'd3);
  endtask

  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (rq.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL rd_extra: got data=%h, required no response", rdata);
      end else begin
        re = rq.pop_front();
        if (re.chk) begin
          checks++;
          if (rdata !== re.data || rresp !== re.resp) begin
            errors++;
            $display("FAIL rd_%h: got data=%h resp=%0d, required data=%h resp=%0d",
                     re.addr, rdata, rresp, re.data, re.resp);
          end
        end
      end
    end
    if (rst_n && bvalid && bready) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wr_extra: got bresp=%0d, required no response", bresp);
      end else begin
        we = wq.pop_front();
        if (bresp !== we.resp) begin
          errors++;
          $display("FAIL wr_%h: got bresp=%0d, required bresp=%0d",
                   we.addr, bresp, we.resp);
        end
      end
    end
  end

  initial begin
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hs: got %b, required 00000",
               {awready, wready, arready, bvalid, rvalid});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk_read(32'h4000_0004, 32'd2);
    chk_read(32'h4000_0010, 32'd0);
    chk_read(32'h8000_0000, 32'd0);
    axi_write(32'h8000_0000, 32'h1234_5678);

    for (int i = 0; i < 1024; i++)
      axi_write(32'hD000_0000 + 32'(4 * i), pat(i));

    axi_write(32'h4000_0010, 32'hC000_0000);
    axi_write(32'h4000_0014, 32'hC000_1000);
    axi_write(32'h4000_0018, 32'd4096);
    axi_write(32'h4000_0000, 32'd1);
    axi_write(32'h4000_0018, 32'd8);
    axi_write(32'h4000_0000, 32'd1);
    chk_read(32'h4000_0004, 32'd0);
    for (int k = 0; k < 16; k++)
      chk_read(32'hD000_0000 + 32'(4 * k), pat(k));
    wait_done();

    for (int k = 0; k < 1024; k++)
      chk_read(32'hD000_1000 + 32'(4 * k), pat(k));
    chk_read(32'hD000_1001, 32'h0302_0100);
    chk_read(32'h4000_001C, BC ? 32'd4096 : 32'd0);

    axi_write(32'hD000_1800, 32'hDEAD_BEEF);
    axi_write(32'h4000_0014, 32'hC000_1800);
    axi_write(32'h4000_0018, 32'd3);
    axi_write(32'h4000_0000, 32'd1);
    chk_read(32'h4000_0004, 32'd3);
    chk_read(32'hD000_1800, 32'hDEAD_BEEF);
    chk_read(32'h4000_001C, 32'd0);

    axi_write(32'h4000_0010, 32'hC000_1FF8);
    axi_write(32'h4000_0018, 32'd16);
    axi_write(32'h4000_0000, 32'd1);
    wait_done();
    chk_read(32'hD000_1800, 32'hFBFA_F9F8);
    chk_read(32'hD000_1804, 32'hFFFE_FDFC);
    chk_read(32'hD000_1808, 32'h0302_0100);
    chk_read(32'hD000_180C, 32'h0706_0504);
    chk_read(32'h4000_001C, BC ? 32'd16 : 32'd0);

    repeat (5) @(posedge clk);
    finish_run();
  end

endmodule
